// File: rtl/score_bcd_enc_if.sv
// Digit interface between the score source and the BCD encoder.
// The master side issues conversion requests; the slave side returns
// packed BCD digits and per-digit leading-zero blank flags.
interface score_bcd_enc_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, bcd, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, blank
    );
endinterface

// File: rtl/score_bcd_enc.sv
// Sequential shift-add-3 binary-to-BCD encoder. One bit is consumed per
// cycle; results and leading-zero blank flags are registered and held
// until the next conversion completes.
module score_bcd_enc #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    score_bcd_enc_if.slave  bus
);
    localparam int SR_W  = 4*DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W+1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
    function automatic bit digits_ok();
        longint unsigned p;
        longint unsigned maxv;
        p    = 1;
        maxv = (64'd1 << BIN_W) - 64'd1;
        for (int i = 0; i < DIGITS; i++) p = p * 64'd10;
        return p > maxv;
    endfunction

    localparam bit DIGITS_OK = digits_ok();

    if (!DIGITS_OK) begin : g_bad_params
        $error("score_bcd_enc: DIGITS too small for BIN_W");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DIGITS-1:0]  blank_nxt;
    logic               run;

    // Add 3 to every BCD nibble >= 5 (no inter-nibble carry), then shift left.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[BIN_W+4*i +: 4] >= 4'd5)
                sr_adj[BIN_W+4*i +: 4] = sr[BIN_W+4*i +: 4] + 4'd3;
        end
        sr_nxt = sr_adj << 1;
    end

    // Leading-zero flags for the digits produced by the final iteration;
    // the ones digit is never blanked so zero still shows as "0".
    always_comb begin
        blank_nxt = '0;
        run       = 1'b1;
        for (int i = DIGITS-1; i >= 1; i--) begin
            run          = run & (sr_nxt[BIN_W+4*i +: 4] == 4'd0);
            blank_nxt[i] = run;
        end
    end

    // Control FSM with registered busy/done/bcd/blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.bcd   <= '0;
            bus.blank <= BLANK_RST;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr       <= {{(4*DIGITS){1'b0}}, bus.bin};
                        cnt      <= CNT_W'(BIN_W);
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= IDLE;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        bus.bcd   <= sr_nxt[SR_W-1 -: 4*DIGITS];
                        bus.blank <= blank_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
